// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg: shared ALU types and scheduler state encoding.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accel_pkg;

  localparam int VECTOR_WIDTH = 16;

  typedef enum logic [1:0] {
    COMP_ADD  = 2'd0,
    COMP_MUL  = 2'd1,
    COMP_RELU = 2'd2,
    COMP_TANH = 2'd3
  } computation_type_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_t;

  localparam int MUL_LATENCY = 1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: one-hot round-robin grant with a rotating priority pointer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic [ID_W:0]   sum;
  logic            found;

  // Scan from the pointer upward, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!found && req[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    gnt = '0;
    if (en && found) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_burst_scheduler.sv
// ---------------------------------------------------------------------------
// alu_burst_scheduler: streams granted bursts into a shared vector_alu and
// aligns MUL and combinational results onto one tagged stream.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_burst_scheduler
  import accel_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  computation_type_t       req_op     [NUM_REQ],
  input  logic [LEN_W-1:0]        req_len    [NUM_REQ],
  input  logic [NUM_REQ-1:0]      opnd_valid,
  output logic [NUM_REQ-1:0]      opnd_ready,
  input  logic [VECTOR_WIDTH-1:0] opnd_a     [NUM_REQ],
  input  logic [VECTOR_WIDTH-1:0] opnd_b     [NUM_REQ],
  output computation_type_t       alu_op,
  output logic [VECTOR_WIDTH-1:0] alu_a,
  output logic [VECTOR_WIDTH-1:0] alu_b,
  input  logic [VECTOR_WIDTH-1:0] alu_result,
  output logic                    res_valid,
  output logic [VECTOR_WIDTH-1:0] res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_last,
  output logic                    busy
);

  sched_state_t      state, state_nxt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_en;
  logic              grant;

  computation_type_t op_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [ID_W-1:0]   gid_q;

  logic              issue;
  logic              last_issue;
  logic              direct_res;
  logic              mul_out;

  logic [MUL_LATENCY-1:0] mul_v_q;
  logic [MUL_LATENCY-1:0] mul_last_q;
  logic [ID_W-1:0]        mul_id_q [MUL_LATENCY];

  assign arb_en = (state == S_IDLE);
  assign grant  = |arb_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign issue      = (state == S_RUN) && opnd_valid[gid_q];
  assign last_issue = issue && (cnt_q == len_q);
  assign direct_res = issue && (op_q != COMP_MUL);
  assign mul_out    = mul_v_q[MUL_LATENCY-1];
  assign alu_op     = op_q;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    opnd_ready = '0;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      S_IDLE: begin
        req_ready = arb_gnt;
        if (grant) state_nxt = S_RUN;
      end
      S_RUN: begin
        opnd_ready[gid_q] = 1'b1;
        alu_a             = opnd_a[gid_q];
        alu_b             = opnd_b[gid_q];
        if (last_issue) state_nxt = (op_q == COMP_MUL) ? S_DRAIN : S_IDLE;
      end
      // One extra cycle keeps alu_op at MUL while the last product is captured.
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= COMP_ADD;
      len_q <= '0;
      cnt_q <= '0;
      gid_q <= '0;
    end else if (arb_en && grant) begin
      op_q  <= req_op[arb_id];
      len_q <= req_len[arb_id];
      gid_q <= arb_id;
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= last_issue ? '0 : cnt_q + LEN_W'(1);
    end
  end

  // MUL issues carry their tag alongside the multiplier register so the
  // product is captured exactly MUL_LATENCY cycles after its own issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_v_q    <= '0;
      mul_last_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_id_q[i] <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
      res_last   <= 1'b0;
    end else begin
      mul_v_q[0]    <= issue && (op_q == COMP_MUL);
      mul_last_q[0] <= last_issue;
      mul_id_q[0]   <= gid_q;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        mul_v_q[i]    <= mul_v_q[i-1];
        mul_last_q[i] <= mul_last_q[i-1];
        mul_id_q[i]   <= mul_id_q[i-1];
      end
      res_valid <= direct_res || mul_out;
      res_last  <= (direct_res && last_issue) || (mul_out && mul_last_q[MUL_LATENCY-1]);
      if (direct_res || mul_out) begin
        res_data <= alu_result;
        res_id   <= mul_out ? mul_id_q[MUL_LATENCY-1] : gid_q;
      end
    end
  end

endmodule

`default_nettype wire
